// File: rtl/calendar_set_ctrl.sv
// Calendar set-mode controller: field selection, key edge/auto-repeat strobes,
// day-carry deferral and digit blinking. Optional edit timeout: CAL_SET_TIMEOUT_EN.
module calendar_set_ctrl #(
  parameter int unsigned HOLD_MS    = 500,
  parameter int unsigned REPEAT_MS  = 100,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned TIMEOUT_MS = 10000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_ms_i,
  input  logic       key_mode_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       day_carry_i,
  output logic [2:0] cnt_inc_o,
  output logic [2:0] cnt_dec_o,
  output logic       full_flag_o,
  output logic       edit_mode_o,
  output logic [5:0] blink_mask_o
);

  if (HOLD_MS == 0 || HOLD_MS > 65535 || REPEAT_MS == 0 || REPEAT_MS > 65535 ||
      BLINK_MS == 0 || BLINK_MS > 65535 || TIMEOUT_MS == 0 || TIMEOUT_MS > 65535) begin : g_bad_param
    $error("calendar_set_ctrl: ms parameters must lie in 1..65535");
  end

  localparam logic [15:0] HOLD_C   = 16'(HOLD_MS);
  localparam logic [15:0] REPEAT_C = 16'(REPEAT_MS);
  localparam logic [15:0] BLINK_C  = 16'(BLINK_MS);

  typedef enum logic [1:0] {IDLE, SET_DAY, SET_MONTH, SET_YEAR} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // key vectors are ordered {mode, up, down}
  logic [2:0]  key_in;
  logic [2:0]  key_q, key_p_q, armed_q;
  logic        tick_q, carry_q;
  state_e      state_q, state_d;
  logic        rep_act_q, rep_act_d, rep_hold_q, rep_hold_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic        pend_q, pend_d;
  logic [2:0]  inc_q, inc_d, dec_q, dec_d;
  logic        full_q, full_d, edit_q, edit_d;
  logic [5:0]  mask_q, mask_d;
  logic [2:0]  rise, sel;
  logic        in_set, up, dn, pulse_up, pulse_dn;
`ifdef CAL_SET_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_MS);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  assign key_in = {key_mode_i, key_up_i, key_down_i};

  always_comb begin
    rise   = key_q & ~key_p_q;
    up     = key_q[1];
    dn     = key_q[0];
    in_set = (state_q != IDLE);

    state_d = state_q;
    if (rise[2]) begin
      case (state_q)
        IDLE:      state_d = SET_DAY;
        SET_DAY:   state_d = SET_MONTH;
        SET_MONTH: state_d = SET_YEAR;
        default:   state_d = IDLE;
      endcase
    end

`ifdef CAL_SET_TIMEOUT_EN
    to_cnt_d = '0;
    if (in_set && key_q == '0) begin
      to_cnt_d = to_cnt_q;
      if (tick_q) begin
        to_cnt_d = sat_inc(to_cnt_q);
        if (to_cnt_d == TIMEOUT_C) begin
          state_d  = IDLE;
          to_cnt_d = '0;
        end
      end
    end
`endif

    case (state_q)
      SET_DAY:   sel = 3'b001;
      SET_MONTH: sel = 3'b010;
      SET_YEAR:  sel = 3'b100;
      default:   sel = 3'b000;
    endcase

    // Auto-repeat only continues a press that started with a clean single-key edge.
    pulse_up   = 1'b0;
    pulse_dn   = 1'b0;
    rep_act_d  = rep_act_q;
    rep_hold_d = rep_hold_q;
    rep_cnt_d  = rep_cnt_q;
    if (!in_set || rise[2] || (up && dn)) begin
      rep_act_d  = 1'b0;
      rep_hold_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (rise[1] || rise[0]) begin
      pulse_up   = rise[1];
      pulse_dn   = rise[0];
      rep_act_d  = 1'b1;
      rep_hold_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (rep_act_q && (up || dn)) begin
      if (tick_q) begin
        rep_cnt_d = sat_inc(rep_cnt_q);
        if (rep_cnt_d == (rep_hold_q ? REPEAT_C : HOLD_C)) begin
          pulse_up   = up;
          pulse_dn   = dn;
          rep_cnt_d  = '0;
          rep_hold_d = 1'b1;
        end
      end
    end else begin
      rep_act_d  = 1'b0;
      rep_hold_d = 1'b0;
      rep_cnt_d  = '0;
    end

    inc_d = pulse_up ? sel : 3'b000;
    dec_d = pulse_dn ? sel : 3'b000;

    full_d = 1'b0;
    pend_d = pend_q;
    if (!in_set) begin
      full_d = carry_q;
      pend_d = 1'b0;
    end else if (state_d == IDLE) begin
      full_d = pend_q | carry_q;
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | carry_q;
    end

    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (in_set) begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (tick_q) begin
        blink_cnt_d = sat_inc(blink_cnt_q);
        if (blink_cnt_d == BLINK_C) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end
      end
    end

    case (state_d)
      SET_DAY:   mask_d = 6'b000011;
      SET_MONTH: mask_d = 6'b001100;
      SET_YEAR:  mask_d = 6'b110000;
      default:   mask_d = 6'b000000;
    endcase
    if (!phase_d || up || dn) mask_d = '0;

    edit_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q       <= '0;
      key_p_q     <= '0;
      armed_q     <= '0;
      tick_q      <= 1'b0;
      carry_q     <= 1'b0;
      state_q     <= IDLE;
      rep_act_q   <= 1'b0;
      rep_hold_q  <= 1'b0;
      rep_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      inc_q       <= '0;
      dec_q       <= '0;
      full_q      <= 1'b0;
      edit_q      <= 1'b0;
      mask_q      <= '0;
`ifdef CAL_SET_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      // A key only counts once it has been seen released since reset.
      key_q       <= key_in & armed_q;
      armed_q     <= armed_q | ~key_in;
      key_p_q     <= key_q;
      tick_q      <= tick_ms_i;
      carry_q     <= day_carry_i;
      state_q     <= state_d;
      rep_act_q   <= rep_act_d;
      rep_hold_q  <= rep_hold_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      full_q      <= full_d;
      edit_q      <= edit_d;
      mask_q      <= mask_d;
`ifdef CAL_SET_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign cnt_inc_o    = inc_q;
  assign cnt_dec_o    = dec_q;
  assign full_flag_o  = full_q;
  assign edit_mode_o  = edit_q;
  assign blink_mask_o = mask_q;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Bench for calendar_set_ctrl: directed scenarios plus random key traffic,
// all compared each cycle against a tick-counting reference model.
module tb_calendar_set_ctrl;
  localparam int unsigned HOLD  = 500;
  localparam int unsigned REP   = 100;
  localparam int unsigned BLINK = 250;
  localparam int unsigned TMO   = 20;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1, tick_ms_i = 1'b0, key_mode_i = 1'b0, key_up_i = 1'b0;
  logic       key_down_i = 1'b0, day_carry_i = 1'b0;
  logic [2:0] cnt_inc_o, cnt_dec_o;
  logic       full_flag_o, edit_mode_o;
  logic [5:0] blink_mask_o;

  calendar_set_ctrl #(.HOLD_MS(HOLD), .REPEAT_MS(REP), .BLINK_MS(BLINK), .TIMEOUT_MS(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .tick_ms_i(tick_ms_i), .key_mode_i(key_mode_i),
    .key_up_i(key_up_i), .key_down_i(key_down_i), .day_carry_i(day_carry_i),
    .cnt_inc_o(cnt_inc_o), .cnt_dec_o(cnt_dec_o), .full_flag_o(full_flag_o),
    .edit_mode_o(edit_mode_o), .blink_mask_o(blink_mask_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state as field index 0..3, hold time as total ticks since press.
  int  m_st, m_held, m_to, m_bt;
  bit  m_pm, m_pu, m_pd, m_rep, m_pend;
  bit  q_m, q_u, q_d, q_t, q_c;
  bit  s_m, s_u, s_d;
  logic [2:0] e_inc, e_dec;
  logic       e_full, e_edit;
  logic [5:0] e_mask;

  task automatic model_reset();
    m_st = 0; m_held = 0; m_to = 0; m_bt = 0;
    m_pm = 0; m_pu = 0; m_pd = 0; m_rep = 0; m_pend = 0;
    q_m = 0; q_u = 0; q_d = 0; q_t = 0; q_c = 0;
    s_m = 0; s_u = 0; s_d = 0;
    e_inc = '0; e_dec = '0; e_full = 0; e_edit = 0; e_mask = '0;
  endtask

  task automatic model_eval();
    bit rise_m, in_set, pu_ev, pd_ev, phase;
    int ns;
    rise_m = q_m && !m_pm;
    in_set = (m_st != 0);
    ns = m_st;
    if (rise_m) ns = (m_st + 1) % 4;
`ifdef CAL_SET_TIMEOUT_EN
    if (in_set && !q_m && !q_u && !q_d) begin
      if (q_t) begin
        m_to++;
        if (m_to == TMO) begin ns = 0; m_to = 0; end
      end
    end else m_to = 0;
`endif
    pu_ev = 0; pd_ev = 0;
    if (!in_set || rise_m || (q_u && q_d)) begin
      m_rep = 0; m_held = 0;
    end else if (q_u && !m_pu) begin
      pu_ev = 1; m_rep = 1; m_held = 0;
    end else if (q_d && !m_pd) begin
      pd_ev = 1; m_rep = 1; m_held = 0;
    end else if (m_rep && (q_u || q_d)) begin
      if (q_t) begin
        m_held++;
        if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REP == 0)) begin
          pu_ev = q_u; pd_ev = q_d;
        end
      end
    end else begin
      m_rep = 0; m_held = 0;
    end
    e_inc = pu_ev ? 3'(1 << (m_st - 1)) : 3'b000;
    e_dec = pd_ev ? 3'(1 << (m_st - 1)) : 3'b000;
    if (!in_set) begin
      e_full = q_c; m_pend = 0;
    end else if (ns == 0) begin
      e_full = m_pend | q_c; m_pend = 0;
    end else begin
      e_full = 0; m_pend = m_pend | q_c;
    end
    if (!in_set) m_bt = 0;
    else if (q_t) m_bt++;
    phase = in_set && ((m_bt / BLINK) % 2 == 1);
    e_mask = (ns != 0 && phase && !q_u && !q_d) ? 6'(3 << (2 * (ns - 1))) : 6'b0;
    e_edit = (ns != 0);
    m_st = ns; m_pm = q_m; m_pu = q_u; m_pd = q_d;
  endtask

  task automatic step(input bit r, input bit m, input bit u, input bit d, input bit t, input bit c);
    @(negedge clk);
    rst_i = r; key_mode_i = m; key_up_i = u; key_down_i = d; tick_ms_i = t; day_carry_i = c;
    @(posedge clk);
    if (r) model_reset();
    else begin
      model_eval();
      q_m = m && s_m; q_u = u && s_u; q_d = d && s_d;
      s_m = s_m || !m; s_u = s_u || !u; s_d = s_d || !d;
      q_t = t; q_c = c;
    end
    #1;
    check_eq("cnt_inc", 16'(cnt_inc_o), 16'(e_inc));
    check_eq("cnt_dec", 16'(cnt_dec_o), 16'(e_dec));
    check_eq("full_flag", 16'(full_flag_o), 16'(e_full));
    check_eq("edit_mode", 16'(edit_mode_o), 16'(e_edit));
    check_eq("blink_mask", 16'(blink_mask_o), 16'(e_mask));
    check_eq("one_strobe", 16'($countones({cnt_inc_o, cnt_dec_o, full_flag_o}) <= 1), 16'd1);
  endtask

  initial begin
    int n, first, last, full_i, idle_i;
    bit cm, cu, cd, prev_edit;
    model_reset();
    repeat (3) step(1, 0, 0, 0, 1, 0);
    check_eq("rst_outputs", 16'({cnt_inc_o, cnt_dec_o, full_flag_o, edit_mode_o, blink_mask_o}), 16'd0);

    // single press in SET_DAY
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check_eq("r41_inc", 16'(cnt_inc_o), 16'b001);
    check_eq("r41_edit", 16'(edit_mode_o), 16'd1);
    step(0, 0, 0, 0, 1, 0);
    check_eq("r41_once", 16'(cnt_inc_o), 16'd0);

    // held key_down in SET_MONTH
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 805; i++) begin
      step(0, 0, 0, (i < 800), 1, 0);
      if (cnt_dec_o == 3'b010) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check_eq("r42_count", 16'(n), 16'd4);
    check_eq("r42_first", 16'(first), 16'd1);
    check_eq("r42_last", 16'(last), 16'd701);

    // two carries in SET_YEAR, flushed once on return to IDLE
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    n = 0; full_i = -1; idle_i = -1; prev_edit = 1;
    for (int i = 0; i < 14; i++) begin
      step(0, (i == 8), 0, 0, 1, (i == 1 || i == 5));
      if (full_flag_o) begin n++; full_i = i; end
      if (prev_edit && !edit_mode_o) idle_i = i;
      prev_edit = edit_mode_o;
    end
    check_eq("r43_count", 16'(n), 16'd1);
    check_eq("r43_first_idle", 16'(full_i), 16'(idle_i));

    // both keys together, then key_up held alone
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    n = 0;
    repeat (5) begin
      step(0, 0, 1, 1, 1, 0);
      if (cnt_inc_o != 0 || cnt_dec_o != 0) n++;
    end
    repeat (1000) begin
      step(0, 0, 1, 0, 1, 0);
      if (cnt_inc_o != 0 || cnt_dec_o != 0) n++;
    end
    check_eq("r44_silent", 16'(n), 16'd0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check_eq("r44_new_edge", 16'(cnt_inc_o), 16'b001);

`ifdef CAL_SET_TIMEOUT_EN
    repeat (25) step(0, 0, 0, 0, 1, 0);
    check_eq("r45_timeout", 16'(edit_mode_o), 16'd0);
    check_eq("r45_mask", 16'(blink_mask_o), 16'd0);
`else
    repeat (1000) step(0, 0, 0, 0, 1, 0);
    check_eq("r45_stay", 16'(edit_mode_o), 16'd1);
`endif

    // reset in the middle of auto-repeat
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (520) step(0, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 1, 0);
    check_eq("r46_zero", 16'({cnt_inc_o, cnt_dec_o, full_flag_o, edit_mode_o, blink_mask_o}), 16'd0);
    n = 0;
    repeat (600) begin
      step(0, 0, 1, 0, 1, 0);
      if (cnt_inc_o != 0 || cnt_dec_o != 0) n++;
    end
    check_eq("r46_no_pulse", 16'(n), 16'd0);

    // key_mode held through reset must not enter SET_DAY
    step(1, 1, 0, 0, 1, 0);
    repeat (5) step(0, 1, 0, 0, 1, 0);
    check_eq("r37_mode_held", 16'(edit_mode_o), 16'd0);
    step(0, 0, 0, 0, 1, 0);

    // random traffic
    cm = 0; cu = 0; cd = 0;
    for (int i = 0; i < 8000; i++) begin
      cm = cm ? ($urandom % 5 != 0) : ($urandom % 150 == 0);
      cu = cu ? ($urandom % 1000 != 0) : ($urandom % 60 == 0);
      cd = cd ? ($urandom % 1000 != 0) : ($urandom % 60 == 0);
      step(($urandom % 3000 == 0), cm, cu, cd, ($urandom % 4 != 0), ($urandom % 40 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
